// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl
// Sequences single-port write and dual-operand read transactions onto an
// external synchronous register file, with round-robin arbitration between
// the write and read requesters.
//
// Ports
//   clk, reset_n                       clock, synchronous active-low reset
//   wr_req_valid/ready, addr, data     write-request handshake and payload
//   rd_req_valid/ready, addrA, addrB   read-request handshake and operand indices
//   rd_rsp_valid/ready, dataA, dataB   read-response handshake and operand values
//   rf_write, rf_wrAddr, rf_wrData     register-file write port
//   rf_rdAddrA/B, rf_rdDataA/B         register-file read port (1-cycle registered read)
//   wr_count, rd_count                 completed-transaction counters (wrap at 256)
module regfile_access_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_req_valid,
  output logic        wr_req_ready,
  input  logic [3:0]  wr_req_addr,
  input  logic [15:0] wr_req_data,
  input  logic        rd_req_valid,
  output logic        rd_req_ready,
  input  logic [3:0]  rd_req_addrA,
  input  logic [3:0]  rd_req_addrB,
  output logic        rd_rsp_valid,
  input  logic        rd_rsp_ready,
  output logic [15:0] rd_rsp_dataA,
  output logic [15:0] rd_rsp_dataB,
  output logic        rf_write,
  output logic [3:0]  rf_wrAddr,
  output logic [15:0] rf_wrData,
  output logic [3:0]  rf_rdAddrA,
  output logic [3:0]  rf_rdAddrB,
  input  logic [15:0] rf_rdDataA,
  input  logic [15:0] rf_rdDataB,
  output logic [7:0]  wr_count,
  output logic [7:0]  rd_count
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    WAIT,
    RESP
  } state_e;

  typedef enum logic {
    GRANT_WRITE,
    GRANT_READ
  } grant_e;

  state_e      state_q, state_d;
  grant_e      grant_q, grant_d;
  logic [3:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [3:0]  rd_addr_a_q, rd_addr_a_d;
  logic [3:0]  rd_addr_b_q, rd_addr_b_d;
  logic [15:0] rsp_a_q, rsp_a_d;
  logic [15:0] rsp_b_q, rsp_b_d;
  logic [7:0]  wr_cnt_q, wr_cnt_d;
  logic [7:0]  rd_cnt_q, rd_cnt_d;

  logic        wr_ready_c;
  logic        rd_ready_c;

  // Readies are gated by reset_n so nothing looks acceptable while reset is
  // held, independent of the (possibly stale) state register. When both
  // requesters are valid, the one not granted last time wins.
  always_comb begin
    wr_ready_c = reset_n && (state_q == IDLE) &&
                 (!rd_req_valid || (grant_q == GRANT_READ));
    rd_ready_c = reset_n && (state_q == IDLE) &&
                 (!wr_req_valid || (grant_q == GRANT_WRITE));
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_addr_a_d = rd_addr_a_q;
    rd_addr_b_d = rd_addr_b_q;
    rsp_a_d     = rsp_a_q;
    rsp_b_d     = rsp_b_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;

    case (state_q)
      IDLE: begin
        if (wr_req_valid && wr_ready_c) begin
          wr_addr_d = wr_req_addr;
          wr_data_d = wr_req_data;
          grant_d   = GRANT_WRITE;
          state_d   = WRITE;
        end else if (rd_req_valid && rd_ready_c) begin
          rd_addr_a_d = rd_req_addrA;
          rd_addr_b_d = rd_req_addrB;
          grant_d     = GRANT_READ;
          state_d     = READ;
        end
      end
      WRITE: begin
        wr_cnt_d = wr_cnt_q + 8'd1;
        state_d  = IDLE;
      end
      // Register file samples rf_rdAddr* at the end of this cycle.
      READ: begin
        state_d = WAIT;
      end
      // Read data from the register file is valid during this cycle.
      WAIT: begin
        rsp_a_d = rf_rdDataA;
        rsp_b_d = rf_rdDataB;
        state_d = RESP;
      end
      RESP: begin
        if (rd_rsp_ready) begin
          rd_cnt_d = rd_cnt_q + 8'd1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_q     <= GRANT_READ;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      rsp_a_q     <= '0;
      rsp_b_q     <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      rsp_a_q     <= rsp_a_d;
      rsp_b_q     <= rsp_b_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
    end
  end

  always_comb begin
    wr_req_ready = wr_ready_c;
    rd_req_ready = rd_ready_c;
    rf_write     = (state_q == WRITE);
    rd_rsp_valid = (state_q == RESP);
    rf_wrAddr    = wr_addr_q;
    rf_wrData    = wr_data_q;
    rf_rdAddrA   = rd_addr_a_q;
    rf_rdAddrB   = rd_addr_b_q;
    rd_rsp_dataA = rsp_a_q;
    rd_rsp_dataB = rsp_b_q;
    wr_count     = wr_cnt_q;
    rd_count     = rd_cnt_q;
  end

  // Arbitration must never offer both grants to two simultaneous requests.
  a_no_double_grant: assert property (@(posedge clk)
    !(wr_req_valid && rd_req_valid && wr_req_ready && rd_req_ready));

endmodule

// File: tb/tb_regfile_access_ctrl.sv
module tb_regfile_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_req_valid, wr_req_ready;
  logic [3:0]  wr_req_addr;
  logic [15:0] wr_req_data;
  logic        rd_req_valid, rd_req_ready;
  logic [3:0]  rd_req_addrA, rd_req_addrB;
  logic        rd_rsp_valid, rd_rsp_ready;
  logic [15:0] rd_rsp_dataA, rd_rsp_dataB;
  logic        rf_write;
  logic [3:0]  rf_wrAddr, rf_rdAddrA, rf_rdAddrB;
  logic [15:0] rf_wrData;
  logic [15:0] rf_rdDataA = '0;
  logic [15:0] rf_rdDataB = '0;
  logic [7:0]  wr_count, rd_count;

  always #5 clk = ~clk;

  regfile_access_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_req_valid (wr_req_valid),
    .wr_req_ready (wr_req_ready),
    .wr_req_addr  (wr_req_addr),
    .wr_req_data  (wr_req_data),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addrA (rd_req_addrA),
    .rd_req_addrB (rd_req_addrB),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_ready (rd_rsp_ready),
    .rd_rsp_dataA (rd_rsp_dataA),
    .rd_rsp_dataB (rd_rsp_dataB),
    .rf_write     (rf_write),
    .rf_wrAddr    (rf_wrAddr),
    .rf_wrData    (rf_wrData),
    .rf_rdAddrA   (rf_rdAddrA),
    .rf_rdAddrB   (rf_rdAddrB),
    .rf_rdDataA   (rf_rdDataA),
    .rf_rdDataB   (rf_rdDataB),
    .wr_count     (wr_count),
    .rd_count     (rd_count)
  );

  // Register file attached to the DUT: registered read, holds read data
  // during a write cycle.
  logic [15:0] rf_mem [16];
  initial for (int i = 0; i < 16; i++) rf_mem[i] = '0;
  always @(posedge clk) begin
    if (rf_write) rf_mem[rf_wrAddr] <= rf_wrData;
    else begin
      rf_rdDataA <= rf_mem[rf_rdAddrA];
      rf_rdDataB <= rf_mem[rf_rdAddrB];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Reference model (transaction level) ----------------
  typedef struct packed { logic [15:0] a; logic [15:0] b; } rsp_t;
  rsp_t        exp_q[$];
  bit          grant_log[$];        // 1 = write granted, 0 = read granted
  logic [15:0] ref_mem [16];
  initial for (int i = 0; i < 16; i++) ref_mem[i] = '0;

  bit          m_last_write = 1'b0; // last granted requester was the writer
  bit          m_wr_busy    = 1'b0; // write occupies the cycle after acceptance
  bit          m_rd_busy    = 1'b0; // read outstanding until response handshake
  int          m_lat        = 0;    // edges elapsed since read acceptance
  bit          m_after_rst  = 1'b0;
  logic [3:0]  m_waddr;
  logic [15:0] m_wdata;
  logic [7:0]  m_wr_cnt     = '0;
  logic [7:0]  m_rd_cnt     = '0;
  int          acc_cnt      = 0;

  // Sampled at negedge: values seen here are the ones the next posedge sees.
  always @(negedge clk) begin
    logic idle, exp_wr_rdy, exp_rd_rdy, exp_valid;
    if (!reset_n) begin
      chk("wr_ready_in_reset", {31'd0, wr_req_ready}, 32'd0);
      chk("rd_ready_in_reset", {31'd0, rd_req_ready}, 32'd0);
      m_last_write = 1'b0;
      m_wr_busy    = 1'b0;
      m_rd_busy    = 1'b0;
      m_lat        = 0;
      m_wr_cnt     = '0;
      m_rd_cnt     = '0;
      exp_q.delete();
      m_after_rst  = 1'b1;
    end else begin
      if (m_after_rst) begin
        chk("rst_rf_wrAddr", {28'd0, rf_wrAddr}, 32'd0);
        chk("rst_rf_wrData", {16'd0, rf_wrData}, 32'd0);
        chk("rst_rf_rdAddrA", {28'd0, rf_rdAddrA}, 32'd0);
        chk("rst_rf_rdAddrB", {28'd0, rf_rdAddrB}, 32'd0);
        chk("rst_rsp_data", {rd_rsp_dataA, rd_rsp_dataB}, 32'd0);
        m_after_rst = 1'b0;
      end
      if (m_rd_busy) m_lat++;
      idle       = !m_wr_busy && !m_rd_busy;
      exp_valid  = m_rd_busy && (m_lat >= 3);
      exp_wr_rdy = idle && (!rd_req_valid || !m_last_write);
      exp_rd_rdy = idle && (!wr_req_valid || m_last_write);
      chk("wr_req_ready", {31'd0, wr_req_ready}, {31'd0, exp_wr_rdy});
      chk("rd_req_ready", {31'd0, rd_req_ready}, {31'd0, exp_rd_rdy});
      chk("rf_write", {31'd0, rf_write}, {31'd0, m_wr_busy});
      chk("rd_rsp_valid", {31'd0, rd_rsp_valid}, {31'd0, exp_valid});
      chk("wr_count", {24'd0, wr_count}, {24'd0, m_wr_cnt});
      chk("rd_count", {24'd0, rd_count}, {24'd0, m_rd_cnt});
      if (m_wr_busy) begin
        chk("rf_wrAddr", {28'd0, rf_wrAddr}, {28'd0, m_waddr});
        chk("rf_wrData", {16'd0, rf_wrData}, {16'd0, m_wdata});
        m_wr_cnt  = m_wr_cnt + 8'd1;
        m_wr_busy = 1'b0;
      end
      if (exp_valid && rd_rsp_ready) begin
        m_rd_cnt  = m_rd_cnt + 8'd1;
        m_rd_busy = 1'b0;
      end
      if (wr_req_valid && exp_wr_rdy) begin
        ref_mem[wr_req_addr] = wr_req_data;
        m_waddr      = wr_req_addr;
        m_wdata      = wr_req_data;
        m_wr_busy    = 1'b1;
        m_last_write = 1'b1;
        grant_log.push_back(1'b1);
        acc_cnt++;
      end else if (rd_req_valid && exp_rd_rdy) begin
        exp_q.push_back({ref_mem[rd_req_addrA], ref_mem[rd_req_addrB]});
        m_rd_busy    = 1'b1;
        m_lat        = 0;
        m_last_write = 1'b0;
        grant_log.push_back(1'b0);
        acc_cnt++;
      end
    end
  end

  // Response monitor: whenever the DUT presents a response, compare it with
  // the oldest expected one; retire it on handshake.
  always @(negedge clk) begin
    if (reset_n && rd_rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        chk("rsp_data", {rd_rsp_dataA, rd_rsp_dataB}, exp_q[0]);
        if (rd_rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- Stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_accept(input int target, input string name);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (acc_cnt >= target) return;
    end
    chk({"timeout_", name}, 32'd1, 32'd0);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    reset_n      = 1'b0;
    wr_req_valid = 1'b0;
    wr_req_addr  = '0;
    wr_req_data  = '0;
    rd_req_valid = 1'b0;
    rd_req_addrA = '0;
    rd_req_addrB = '0;
    rd_rsp_ready = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Write 3 <- BEEF, then read (3, 0).
    wr_req_valid = 1'b1; wr_req_addr = 4'h3; wr_req_data = 16'hBEEF;
    wait_accept(acc_cnt + 1, "wr_beef");
    wr_req_valid = 1'b0;
    rd_rsp_ready = 1'b1;
    rd_req_valid = 1'b1; rd_req_addrA = 4'h3; rd_req_addrB = 4'h0;
    wait_accept(acc_cnt + 1, "rd_beef");
    rd_req_valid = 1'b0;
    repeat (6) tick();
    chk("rd_count_after_first", {24'd0, rd_count}, 32'd1);

    // Contention straight after reset: grants must go W, R, W, R.
    pulse_reset();
    grant_log.delete();
    wr_req_valid = 1'b1; rd_req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_req_addr  = 4'($urandom_range(15));
      wr_req_data  = 16'($urandom_range(16'hFFFF));
      tick();
    end
    wr_req_valid = 1'b0; rd_req_valid = 1'b0;
    repeat (6) tick();
    chk("grant_count", {31'd0, grant_log.size() >= 4}, 32'd1);
    if (grant_log.size() >= 4) begin
      chk("grant0_W", {31'd0, grant_log[0]}, 32'd1);
      chk("grant1_R", {31'd0, grant_log[1]}, 32'd0);
      chk("grant2_W", {31'd0, grant_log[2]}, 32'd1);
      chk("grant3_R", {31'd0, grant_log[3]}, 32'd0);
    end

    // Response back-pressure with a write pending behind it.
    rd_rsp_ready = 1'b0;
    rd_req_valid = 1'b1; rd_req_addrA = 4'h3; rd_req_addrB = 4'h7;
    wait_accept(acc_cnt + 1, "rd_stall");
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b1; wr_req_addr = 4'h7; wr_req_data = 16'h1234;
    repeat (13) tick();
    rd_rsp_ready = 1'b1;
    wait_accept(acc_cnt + 1, "wr_after_stall");
    wr_req_valid = 1'b0;
    repeat (3) tick();

    // Reset while in WAIT: response dropped, counters cleared.
    rd_req_valid = 1'b1; rd_req_addrA = 4'h7; rd_req_addrB = 4'h3;
    wait_accept(acc_cnt + 1, "rd_reset");
    rd_req_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("wr_count_after_rst", {24'd0, wr_count}, 32'd0);
    chk("rd_count_after_rst", {24'd0, rd_count}, 32'd0);

    // 256 writes: counter wraps back to 0.
    for (int i = 0; i < 256; i++) begin
      wr_req_valid = 1'b1;
      wr_req_addr  = 4'($urandom_range(15));
      wr_req_data  = 16'($urandom_range(16'hFFFF));
      wait_accept(acc_cnt + 1, "wr_wrap");
    end
    wr_req_valid = 1'b0;
    repeat (3) tick();
    chk("wr_count_wrap", {24'd0, wr_count}, 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      wr_req_valid = 1'($urandom_range(1));
      wr_req_addr  = 4'($urandom_range(15));
      wr_req_data  = 16'($urandom_range(16'hFFFF));
      rd_req_valid = 1'($urandom_range(1));
      rd_req_addrA = 4'($urandom_range(15));
      rd_req_addrB = 4'($urandom_range(15));
      rd_rsp_ready = ($urandom_range(3) != 0);
      tick();
    end
    wr_req_valid = 1'b0; rd_req_valid = 1'b0; rd_rsp_ready = 1'b1;
    repeat (10) tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
